mac_accumulator: RTL and testbench

Signed multiply-accumulate back end sitting directly downstream of the combinational 8x8 signed Wallace-tree multiplier. It consumes the 16-bit two's-complement product stream through a valid/ready handshake and sums products over a vector delimited by `p_last`. It presents one registered result per vector, with term count and overflow flag, through a second valid/ready handshake. Dot-product / FIR engines in this codebase use it as their accumulation stage.

---
 rtl/mac_accumulator.sv | 95 +++++++++
 tb/tb_mac_accumulator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: signed multiply-accumulate back end.
// Sums a stream of 16-bit signed products over a vector delimited by p_last
// and presents one registered result (sum, term count, overflow flag) per
// vector through a valid/ready handshake.
module mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [15:0]      p,
    input  logic             p_last,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [ACC_W-1:0] r_acc,
    output logic [CNT_W-1:0] r_count,
    output logic             r_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Partial-vector state
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;

    // Next-value candidates for the term being accepted
    logic [ACC_W:0]   nsum;
    logic             add_ovf;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             accept;

    // Input stalls only while a result is held and the consumer is not taking it
    assign p_ready = !rst && !clr && (!r_valid || r_ready);
    assign accept  = p_valid && p_ready;

    // Add one term with one guard bit; clamp or wrap on signed overflow
    always_comb begin
        nsum     = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W-15){p[15]}}, p};
        add_ovf  = nsum[ACC_W] ^ nsum[ACC_W-1];
        sum_next = nsum[ACC_W-1:0];
        if (SAT && add_ovf) begin
            sum_next = nsum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
        ovf_next = ovf_reg | add_ovf;
    end

    // Accumulator: flushed by clr, restarted after each last term
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (clr || (accept && p_last)) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

    // Result registers: load on a last-term accept, release on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (accept && p_last) begin
                r_acc   <= sum_next;
                r_count <= cnt_next;
                r_ovf   <= ovf_next;
            end
            // A new result arriving in the handshake cycle keeps r_valid high
            if (accept && p_last) begin
                r_valid <= 1'b1;
            end else if (r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: three parameterisations of mac_accumulator share one
// stimulus stream and are compared each cycle against an arithmetic model
// (plain integer sums with clamp or modular wrap).
module tb_mac_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        p_valid = 1'b0;
    logic        p_last = 1'b0;
    logic        r_ready = 1'b0;
    logic [15:0] p = 16'h0;

    logic        p_ready0, p_ready1, p_ready2;
    logic        r_valid0, r_valid1, r_valid2;
    logic [23:0] r_acc0;
    logic [16:0] r_acc1, r_acc2;
    logic [7:0]  r_count0, r_count1;
    logic [3:0]  r_count2;
    logic        r_ovf0, r_ovf1, r_ovf2;

    mac_accumulator #(.ACC_W(24), .CNT_W(8), .SAT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .p_valid(p_valid), .p_ready(p_ready0),
        .p(p), .p_last(p_last), .r_valid(r_valid0), .r_ready(r_ready),
        .r_acc(r_acc0), .r_count(r_count0), .r_ovf(r_ovf0));

    mac_accumulator #(.ACC_W(17), .CNT_W(8), .SAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .p_valid(p_valid), .p_ready(p_ready1),
        .p(p), .p_last(p_last), .r_valid(r_valid1), .r_ready(r_ready),
        .r_acc(r_acc1), .r_count(r_count1), .r_ovf(r_ovf1));

    mac_accumulator #(.ACC_W(17), .CNT_W(4), .SAT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .p_valid(p_valid), .p_ready(p_ready2),
        .p(p), .p_last(p_last), .r_valid(r_valid2), .r_ready(r_ready),
        .r_acc(r_acc2), .r_count(r_count2), .r_ovf(r_ovf2));

    localparam int AW [3] = '{24, 17, 17};
    localparam int CW [3] = '{8, 8, 4};
    localparam bit SW [3] = '{1'b1, 1'b1, 1'b0};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint m_acc [3];
    longint m_racc [3];
    int     m_cnt [3];
    int     m_rcnt [3];
    bit     m_ovf [3];
    bit     m_rovf [3];
    bit     m_rvalid;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint obs_acc(input int k);
        case (k)
            0:       return longint'($signed(r_acc0));
            1:       return longint'($signed(r_acc1));
            default: return longint'($signed(r_acc2));
        endcase
    endfunction

    function automatic longint obs_cnt(input int k);
        case (k)
            0:       return longint'(r_count0);
            1:       return longint'(r_count1);
            default: return longint'(r_count2);
        endcase
    endfunction

    function automatic longint obs_ovf(input int k);
        case (k)
            0:       return longint'(r_ovf0);
            1:       return longint'(r_ovf1);
            default: return longint'(r_ovf2);
        endcase
    endfunction

    function automatic longint obs_valid(input int k);
        case (k)
            0:       return longint'(r_valid0);
            1:       return longint'(r_valid1);
            default: return longint'(r_valid2);
        endcase
    endfunction

    function automatic longint obs_ready(input int k);
        case (k)
            0:       return longint'(p_ready0);
            1:       return longint'(p_ready1);
            default: return longint'(p_ready2);
        endcase
    endfunction

    // Exact integer add, then clamp or wrap into the signed w-bit range
    task automatic add_term(input longint a, input longint t, input int w, input bit sat,
                            output longint r, output bit o);
        longint s, hi, lo, span;
        s    = a + t;
        span = longint'(1) <<< w;
        hi   = (longint'(1) <<< (w - 1)) - 1;
        lo   = -(longint'(1) <<< (w - 1));
        o    = (s > hi) || (s < lo);
        if (!o) r = s;
        else if (sat) r = (s > hi) ? hi : lo;
        else begin
            r = s & (span - 1);
            if (r > hi) r = r - span;
        end
    endtask

    // One clock: check ready, advance the model on the edge, check outputs after it
    task automatic tick();
        bit     exp_ready, acc_now, o;
        longint s;
        int     c;
        #1;
        exp_ready = !rst && !clr && (!m_rvalid || r_ready);
        for (int k = 0; k < 3; k++)
            check($sformatf("p_ready[%0d]", k), obs_ready(k), longint'(exp_ready));
        acc_now = p_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                m_racc[k] = 0; m_rcnt[k] = 0; m_rovf[k] = 0;
            end
            m_rvalid = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (clr) begin
                    m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                end else if (acc_now) begin
                    add_term(m_acc[k], longint'($signed(p)), AW[k], SW[k], s, o);
                    c = (m_cnt[k] + 1 > (1 << CW[k]) - 1) ? (1 << CW[k]) - 1 : m_cnt[k] + 1;
                    if (p_last) begin
                        m_racc[k] = s; m_rcnt[k] = c; m_rovf[k] = m_ovf[k] | o;
                        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                    end else begin
                        m_acc[k] = s; m_cnt[k] = c; m_ovf[k] = m_ovf[k] | o;
                    end
                end
            end
            if (acc_now && p_last) m_rvalid = 1;
            else if (r_ready) m_rvalid = 0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("r_valid[%0d]", k), obs_valid(k), longint'(m_rvalid));
            check($sformatf("r_acc[%0d]", k), obs_acc(k), m_racc[k]);
            check($sformatf("r_count[%0d]", k), obs_cnt(k), longint'(m_rcnt[k]));
            check($sformatf("r_ovf[%0d]", k), obs_ovf(k), longint'(m_rovf[k]));
        end
    endtask

    task automatic drv(input logic v, input logic [15:0] pv, input logic l);
        p_valid = v;
        p       = pv;
        p_last  = l;
        tick();
        $display("txn t=%0t v=%0b p=%h last=%0b rr=%0b clr=%0b rst=%0b -> rv=%0b acc0=%0d cnt0=%0d",
                 $time, v, pv, l, r_ready, clr, rst, r_valid0, $signed(r_acc0), r_count0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            m_racc[k] = 0; m_rcnt[k] = 0; m_rovf[k] = 0;
        end
        m_rvalid = 0;

        // Reset
        @(negedge clk);
        rst = 1'b1;
        drv(1'b1, 16'h1234, 1'b1);
        drv(1'b1, 16'h1234, 1'b1);
        check("rst_ready", longint'(p_ready0), 0);
        check("rst_acc", obs_acc(0), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", longint'(p_ready0), 1);

        // Basic vector
        r_ready = 1'b1;
        drv(1'b1, 16'h4000, 1'b0);
        drv(1'b1, 16'h4000, 1'b0);
        drv(1'b1, 16'h4000, 1'b1);
        check("basic_valid", obs_valid(0), 1);
        check("basic_acc", obs_acc(0), 49152);
        check("basic_cnt", obs_cnt(0), 3);
        check("basic_ovf", obs_ovf(0), 0);

        // Negative mix
        drv(1'b1, 16'hC080, 1'b0);
        drv(1'b1, 16'h3F01, 1'b1);
        check("neg_acc", obs_acc(0), -127);
        check("neg_raw", longint'(r_acc0), longint'(24'hFFFF81));
        check("neg_cnt", obs_cnt(0), 2);

        // Saturation / wrap at 17 bits
        for (int i = 0; i < 5; i++) drv(1'b1, 16'h4000, i == 4);
        check("sat_acc17", obs_acc(1), 65535);
        check("sat_ovf17", obs_ovf(1), 1);
        check("wrap_raw17", longint'(r_acc2), longint'(17'h14000));
        check("wrap_ovf17", obs_ovf(2), 1);
        check("nosat_acc24", obs_acc(0), 81920);
        check("nosat_ovf24", obs_ovf(0), 0);

        // Backpressure while the result is held
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 16'h0009, 1'b0);
            check("bp_hold_acc", obs_acc(0), 81920);
        end
        r_ready = 1'b1;
        drv(1'b1, 16'h0005, 1'b1);
        check("bp_valid", obs_valid(0), 1);
        check("bp_acc", obs_acc(0), 5);
        check("bp_cnt", obs_cnt(0), 1);

        // Flush
        drv(1'b1, 16'h0100, 1'b0);
        drv(1'b1, 16'h0100, 1'b0);
        clr = 1'b1;
        drv(1'b1, 16'h0100, 1'b0);
        clr = 1'b0;
        drv(1'b1, 16'h0007, 1'b1);
        check("flush_acc", obs_acc(0), 7);
        check("flush_cnt", obs_cnt(0), 1);

        // Reset while a result is held
        r_ready = 1'b0;
        drv(1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        drv(1'b0, 16'h0000, 1'b0);
        check("rst_held_valid", obs_valid(0), 0);
        check("rst_held_acc", obs_acc(0), 0);
        check("rst_held_cnt", obs_cnt(0), 0);
        rst = 1'b0;

        // Back-to-back vectors
        r_ready = 1'b1;
        drv(1'b1, 16'h0003, 1'b1);
        drv(1'b1, 16'h0001, 1'b0);
        drv(1'b1, 16'h0001, 1'b1);
        check("b2b_acc", obs_acc(0), 2);
        check("b2b_cnt", obs_cnt(0), 2);

        // Long vectors: positive clamp, count saturation, negative clamp
        for (int i = 0; i < 600; i++) drv(1'b1, 16'h4000, i == 599);
        check("long_acc24", obs_acc(0), 8388607);
        check("long_cnt8", obs_cnt(0), 255);
        check("long_cnt4", obs_cnt(2), 15);
        for (int i = 0; i < 300; i++) drv(1'b1, 16'h8000, i == 299);
        check("neg_clamp24", obs_acc(0), -8388608);
        check("neg_clamp_ovf", obs_ovf(0), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            r_ready = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       p = 16'h7FFF;
                1:       p = 16'h8000;
                default: p = 16'($urandom);
            endcase
            drv($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) < 2);
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
